// File: rtl/qdec_cabac_dec_arb_pkg.sv
// ---------------------------------------------------------------------------
// qdec_cabac_dec_arb_pkg
//   Shared types and constants for the CABAC decode-engine arbiter.
//   - t_state_arb     : arbiter FSM states
//   - NUM_CABAC_REQ   : number of syntax sub-FSMs sharing the engine
//   - REQ_*           : requester slot assignment on the req/grant vectors
// ---------------------------------------------------------------------------
package qdec_cabac_dec_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_DRAIN = 2'd2
    } t_state_arb;

    localparam int NUM_CABAC_REQ = 6;

    localparam int REQ_SAO  = 0;
    localparam int REQ_CU   = 1;
    localparam int REQ_CQP  = 2;
    localparam int REQ_TU   = 3;
    localparam int REQ_RES  = 4;
    localparam int REQ_MISC = 5;

endpackage

// File: rtl/qdec_cabac_dec_arb_if.sv
// ---------------------------------------------------------------------------
// qdec_cabac_dec_arb_if
//   Bundles the requester side (sub-FSMs) and the engine side
//   (qdec_cabac_bin_dec / context memory) of the decode arbiter.
//   modport master : the arbiter
//   modport slave  : the environment (sub-FSMs plus engine)
//   Requester side : req, ctx_addr_in, ctx_addr_vld_in, dec_run_in, EPMode_in,
//                    grant, dec_rdy_out, ruiBin_out, ruiBin_vld_out
//   Engine side    : ctx_addr, ctx_addr_vld, dec_run, EPMode,
//                    dec_rdy, ruiBin, ruiBin_vld
//   Status         : busy, err_proto
// ---------------------------------------------------------------------------
interface qdec_cabac_dec_arb_if #(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] ctx_addr_in;
    logic [NUM_REQ-1:0]        ctx_addr_vld_in;
    logic [NUM_REQ-1:0]        dec_run_in;
    logic [NUM_REQ-1:0]        EPMode_in;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        dec_rdy_out;
    logic                      ruiBin_out;
    logic [NUM_REQ-1:0]        ruiBin_vld_out;
    logic [ADDR_W-1:0]         ctx_addr;
    logic                      ctx_addr_vld;
    logic                      dec_run;
    logic                      EPMode;
    logic                      dec_rdy;
    logic                      ruiBin;
    logic                      ruiBin_vld;
    logic                      busy;
    logic [2:0]                err_proto;

    modport master (
        input  req, ctx_addr_in, ctx_addr_vld_in, dec_run_in, EPMode_in,
               dec_rdy, ruiBin, ruiBin_vld,
        output grant, dec_rdy_out, ruiBin_out, ruiBin_vld_out,
               ctx_addr, ctx_addr_vld, dec_run, EPMode, busy, err_proto
    );

    modport slave (
        output req, ctx_addr_in, ctx_addr_vld_in, dec_run_in, EPMode_in,
               dec_rdy, ruiBin, ruiBin_vld,
        input  grant, dec_rdy_out, ruiBin_out, ruiBin_vld_out,
               ctx_addr, ctx_addr_vld, dec_run, EPMode, busy, err_proto
    );

endinterface

// File: rtl/qdec_cabac_dec_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// qdec_rr_pick
//   Combinational round-robin picker. Scans i_req starting one above i_ptr
//   (with wrap) and returns the first set bit.
//   i_req   : request vector
//   i_ptr   : index of the previous winner
//   o_grant : one-hot winner (0 when nothing requested)
//   o_idx   : index of the winner
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module qdec_rr_pick #(
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/qdec_cabac_dec_arb.sv
// ---------------------------------------------------------------------------
// qdec_cabac_dec_arb
//   Shares the CABAC bin decoding engine and context memory among the syntax
//   sub-FSMs. One owner at a time is granted (round robin); its context
//   address / decode strobes are forwarded combinationally to the engine and
//   the engine's ready / bin results are routed back to it. The grant is held
//   until the owner drops req and every issued bin has returned.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requester + engine + status signals (master modport)
// ---------------------------------------------------------------------------
module qdec_cabac_dec_arb
`ifndef IVERILOG
    import qdec_cabac_dec_arb_pkg::*;
`endif
#(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qdec_cabac_dec_arb_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    t_state_arb          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt, w_pick;
    logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt, w_pick_idx;
    logic                w_pick_any;
    logic [1:0]          r_outst, w_outst_nxt;
    logic [2:0]          r_err;
    logic [ADDR_W-1:0]   r_ctx_addr, w_ctx_addr_sel;
    logic                w_fwd_en, w_own_req, w_own_run, w_own_av, w_own_ep;
    logic                w_dec, w_bin_err, w_ovf, w_nonown;

    qdec_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Owner's issue strobes only reach the engine in ARB_GRANT; in ARB_DRAIN
    // the grant is kept solely to route the remaining bins back.
    assign w_fwd_en  = (r_state == ARB_GRANT);
    assign w_own_req = |(bus.req & r_grant);
    assign w_own_run = w_fwd_en & |(bus.dec_run_in & r_grant);
    assign w_own_av  = w_fwd_en & |(bus.ctx_addr_vld_in & r_grant);
    assign w_own_ep  = |(bus.EPMode_in & r_grant);
    assign w_nonown  = |((bus.dec_run_in | bus.ctx_addr_vld_in) & ~r_grant);

    // A bin returning with nothing outstanding is a protocol error, not routed.
    assign w_dec     = bus.ruiBin_vld & (r_outst != 2'd0);
    assign w_bin_err = bus.ruiBin_vld & (r_outst == 2'd0);

    always_comb begin
        w_ctx_addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_ctx_addr_sel = bus.ctx_addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_outst_nxt = r_outst;
        w_ovf       = 1'b0;
        if (w_own_run && !w_dec) begin
            if (r_outst == 2'd3) begin
                w_ovf = 1'b1;
            end else begin
                w_outst_nxt = r_outst + 2'd1;
            end
        end else if (w_dec && !w_own_run) begin
            w_outst_nxt = r_outst - 2'd1;
        end
    end

    // Next-state: release is judged on the post-edge outstanding count so a
    // bin issued in the release cycle is still drained.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt  = ARB_GRANT;
                    w_grant_nxt  = w_pick;
                    w_rr_ptr_nxt = w_pick_idx;
                end
            end
            ARB_GRANT: begin
                if (!w_own_req) begin
                    if (w_outst_nxt == 2'd0) begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                    end else begin
                        w_state_nxt = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                if (w_outst_nxt == 2'd0) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_outst    <= 2'd0;
            r_err      <= 3'b000;
            r_ctx_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_outst  <= w_outst_nxt;
            r_err    <= r_err | {w_ovf, w_bin_err, w_nonown};
            if (w_own_av) begin
                r_ctx_addr <= w_ctx_addr_sel;
            end
        end
    end

    assign bus.grant          = r_grant;
    assign bus.dec_rdy_out    = r_grant & {NUM_REQ{bus.dec_rdy}};
    assign bus.ruiBin_out     = bus.ruiBin;
    assign bus.ruiBin_vld_out = w_dec ? r_grant : '0;
    assign bus.ctx_addr       = w_own_av ? w_ctx_addr_sel : r_ctx_addr;
    assign bus.ctx_addr_vld   = w_own_av;
    assign bus.dec_run        = w_own_run;
    assign bus.EPMode         = w_own_ep;
    assign bus.busy           = (r_state != ARB_IDLE);
    assign bus.err_proto      = r_err;

endmodule

// File: tb/tb_qdec_cabac_dec_arb.sv
// ---------------------------------------------------------------------------
// tb_qdec_cabac_dec_arb
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (owner index, release flag, bins-in-flight count, sticky error bits)
//   predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_qdec_cabac_dec_arb;

    localparam int N  = 6;
    localparam int AW = 10;

    logic clk;
    logic rst_n;

    qdec_cabac_dec_arb_if #(.NUM_REQ(N), .ADDR_W(AW)) u_if ();

    qdec_cabac_dec_arb #(.NUM_REQ(N), .ADDR_W(AW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    int            m_owner;   // -1 when nobody owns the engine
    int            m_ptr;     // last winner
    int            m_out;     // bins in flight
    bit            m_rel;     // owner has released, waiting for bins
    bit            m_known;   // model aligned with DUT after first reset
    logic [2:0]    m_err;
    logic [AW-1:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        u_if.ctx_addr_vld_in = '0;
        u_if.dec_run_in      = '0;
        u_if.EPMode_in       = '0;
        u_if.ruiBin_vld      = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model
    // as the edge would, then return at posedge+1.
    task automatic step();
        logic [N-1:0]  eg;
        logic [AW-1:0] oaddr;
        bit            edr, eav, eep, er;
        @(negedge clk);
        eg = '0; oaddr = '0; edr = 0; eav = 0; eep = 0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            oaddr = u_if.ctx_addr_in[m_owner*AW +: AW];
            eep   = u_if.EPMode_in[m_owner];
            if (!m_rel) begin
                edr = u_if.dec_run_in[m_owner];
                eav = u_if.ctx_addr_vld_in[m_owner];
            end
        end
        er = u_if.ruiBin_vld && (m_out > 0);
        if (m_known) begin
            check("grant",      32'(u_if.grant), 32'(eg));
            check("dec_rdy",    32'(u_if.dec_rdy_out), u_if.dec_rdy ? 32'(eg) : 32'd0);
            check("ruiBin",     32'(u_if.ruiBin_out), 32'(u_if.ruiBin));
            check("bin_vld",    32'(u_if.ruiBin_vld_out), er ? 32'(eg) : 32'd0);
            check("ctx_addr",   32'(u_if.ctx_addr), eav ? 32'(oaddr) : 32'(m_addr));
            check("ctx_vld",    32'(u_if.ctx_addr_vld), 32'(eav));
            check("dec_run",    32'(u_if.dec_run), 32'(edr));
            check("EPMode",     32'(u_if.EPMode), 32'(eep));
            check("busy",       32'(u_if.busy), 32'(m_owner >= 0));
            check("err",        32'(u_if.err_proto), 32'(m_err));
        end
        if (!rst_n) begin
            m_owner = -1; m_ptr = N - 1; m_out = 0; m_rel = 0;
            m_err = '0; m_addr = '0; m_known = 1;
        end else begin
            for (int i = 0; i < N; i++)
                if ((u_if.dec_run_in[i] || u_if.ctx_addr_vld_in[i]) && i != m_owner)
                    m_err[0] = 1'b1;
            if (u_if.ruiBin_vld && m_out == 0) m_err[1] = 1'b1;
            if (edr && !er) begin
                if (m_out == 3) m_err[2] = 1'b1;
                else m_out++;
            end else if (er && !edr) begin
                m_out--;
            end
            if (eav) m_addr = oaddr;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_owner < 0 && u_if.req[c]) begin
                        m_owner = c;
                        m_ptr   = c;
                    end
                end
            end else begin
                if (!m_rel && !u_if.req[m_owner]) m_rel = 1;
                if (m_rel && m_out == 0) begin
                    m_owner = -1;
                    m_rel   = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] rnd64;
        m_owner = -1; m_ptr = N - 1; m_out = 0; m_rel = 0; m_known = 0;
        m_err = '0; m_addr = '0;
        rst_n = 1'b0;
        u_if.req = '0; u_if.ctx_addr_in = '0; u_if.dec_rdy = 1'b0; u_if.ruiBin = 1'b0;
        clr_in();
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;
        check("rst_grant", 32'(u_if.grant), 32'd0);
        check("rst_busy",  32'(u_if.busy), 32'd0);
        check("rst_err",   32'(u_if.err_proto), 32'd0);
        check("rst_addr",  32'(u_if.ctx_addr), 32'd0);

        // Single requester 2 with three context bins
        u_if.req = 6'b000100;
        step();
        check("s1_grant", 32'(u_if.grant), 32'b000100);
        for (int b = 0; b < 3; b++) begin
            u_if.ctx_addr_in[2*AW +: AW] = AW'($urandom);
            u_if.ctx_addr_vld_in[2] = 1'b1;
            step();
            u_if.ctx_addr_vld_in[2] = 1'b0;
            u_if.dec_run_in[2] = 1'b1;
            step();
            u_if.dec_run_in[2] = 1'b0;
            step();
            u_if.ruiBin_vld = 1'b1;
            #1 check("s1_binvld", 32'(u_if.ruiBin_vld_out), 32'b000100);
            step();
            u_if.ruiBin_vld = 1'b0;
        end
        step(); step();
        u_if.req = '0;
        step();
        check("s1_release", 32'(u_if.grant), 32'd0);
        step();

        // Two requesters from reset: 0 first, then 5, then 0 again
        do_reset();
        u_if.req = 6'b100001;
        step();
        check("s2_first", 32'(u_if.grant), 32'b000001);
        u_if.req = 6'b100000;
        step();
        check("s2_gap", 32'(u_if.grant), 32'd0);
        step();
        check("s2_second", 32'(u_if.grant), 32'b100000);
        u_if.req = 6'b100001;
        step(); step();
        u_if.req = 6'b000001;
        step(); step();
        check("s2_third", 32'(u_if.grant), 32'b000001);
        u_if.req = '0;
        step(); step();

        // Release with one bin in flight -> drain
        u_if.req = 6'b000010;
        step();
        u_if.dec_run_in[1] = 1'b1;
        step();
        u_if.dec_run_in[1] = 1'b0;
        u_if.req = '0;
        step();
        check("s3_drain_busy", 32'(u_if.busy), 32'd1);
        check("s3_drain_grant", 32'(u_if.grant), 32'b000010);
        step(); step();
        u_if.ruiBin_vld = 1'b1;
        #1 check("s3_binvld", 32'(u_if.ruiBin_vld_out), 32'b000010);
        step();
        u_if.ruiBin_vld = 1'b0;
        check("s3_idle", 32'(u_if.busy), 32'd0);

        // Non-owner issue
        u_if.req = 6'b000001;
        step();
        u_if.dec_run_in[3] = 1'b1;
        #1 check("s4_run_masked", 32'(u_if.dec_run), 32'd0);
        step();
        u_if.dec_run_in[3] = 1'b0;
        check("s4_err0", 32'(u_if.err_proto), 32'b001);
        u_if.req = '0;
        step(); step();
        do_reset();

        // Stray bin with nothing in flight
        u_if.ruiBin_vld = 1'b1;
        #1 check("s5_no_route", 32'(u_if.ruiBin_vld_out), 32'd0);
        step();
        u_if.ruiBin_vld = 1'b0;
        check("s5_err1", 32'(u_if.err_proto), 32'b010);
        do_reset();

        // Four bins without response -> overflow, then reset inside drain
        u_if.req = 6'b000001;
        step();
        u_if.dec_run_in[0] = 1'b1;
        repeat (4) step();
        u_if.dec_run_in[0] = 1'b0;
        check("s6_err2", 32'(u_if.err_proto), 32'b100);
        u_if.req = '0;
        step();
        check("s6_drain", 32'(u_if.busy), 32'd1);
        rst_n = 1'b0;
        u_if.dec_run_in[0] = 1'b1;
        u_if.ctx_addr_vld_in[0] = 1'b1;
        u_if.EPMode_in[0] = 1'b1;
        step();
        check("s7_grant", 32'(u_if.grant), 32'd0);
        check("s7_busy",  32'(u_if.busy), 32'd0);
        check("s7_err",   32'(u_if.err_proto), 32'd0);
        check("s7_eng",   32'({u_if.dec_run, u_if.ctx_addr_vld, u_if.EPMode}), 32'd0);
        check("s7_addr",  32'(u_if.ctx_addr), 32'd0);
        clr_in();
        rst_n = 1'b1;
        u_if.ruiBin_vld = 1'b1;
        step();
        u_if.ruiBin_vld = 1'b0;
        check("s7_late_bin", 32'(u_if.err_proto), 32'b010);
        do_reset();

        // Randomized well-behaved traffic with rare protocol violations
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                if (m_owner == i && !m_rel) begin
                    if ($urandom_range(0, 11) == 0) u_if.req[i] = 1'b0;
                end else if (!u_if.req[i] && $urandom_range(0, 7) == 0) begin
                    u_if.req[i] = 1'b1;
                end
            end
            rnd64 = {$urandom, $urandom};
            u_if.ctx_addr_in = rnd64[N*AW-1:0];
            clr_in();
            u_if.EPMode_in = N'($urandom_range(0, (1 << N) - 1));
            if (m_owner >= 0 && !m_rel) begin
                if ($urandom_range(0, 2) == 0) u_if.ctx_addr_vld_in[m_owner] = 1'b1;
                if ($urandom_range(0, 2) == 0 && (m_out < 3 || $urandom_range(0, 19) == 0))
                    u_if.dec_run_in[m_owner] = 1'b1;
            end
            if (m_owner >= 0 && m_rel && $urandom_range(0, 9) == 0)
                u_if.dec_run_in[m_owner] = 1'b1;
            if ($urandom_range(0, 149) == 0)
                u_if.dec_run_in[$urandom_range(0, N - 1)] = 1'b1;
            u_if.ruiBin_vld = (m_out > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
            u_if.ruiBin  = 1'($urandom_range(0, 1));
            u_if.dec_rdy = 1'($urandom_range(0, 1));
            step();
            if (cyc % 250 == 249) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
